board_loader: RTL

- Parametrised successor to the single-cycle board selector.
- Holds NUM_BOARDS preset puzzles, of size N x N. On request it copies the selected preset into the live game_board/game_status registers, one cell per cycle.
- After loading it arbitrates player cell writes, rejecting writes to fixed (given) cells and out-of-range values.
- Sits between the preset puzzle storage and the game logic/display.

---
 rtl/board_loader_if.sv | 37 +++
 rtl/board_loader.sv | 127 ++++++++++++
 2 files changed

// File: rtl/board_loader_if.sv
// Bundle between the board loader, the preset store and the game logic.
// Presets and player writes flow in; the live board and status pulses flow out.
interface board_loader_if #(
    parameter int N          = 9,
    parameter int VAL_W      = 4,
    parameter int STATUS_W   = 4,
    parameter int NUM_BOARDS = 2,
    parameter int SEL_W      = 1
);
    logic                                             board_enable;
    logic [SEL_W-1:0]                                 board_sel;
    logic [NUM_BOARDS-1:0][N-1:0][N-1:0][VAL_W-1:0]    initial_boards;
    logic [NUM_BOARDS-1:0][N-1:0][N-1:0][STATUS_W-1:0] initial_statuses;
    logic                                             wr_en;
    logic [3:0]                                       wr_row;
    logic [3:0]                                       wr_col;
    logic [VAL_W-1:0]                                 wr_value;
    logic [N-1:0][N-1:0][VAL_W-1:0]                   game_board;
    logic [N-1:0][N-1:0][STATUS_W-1:0]                game_status;
    logic                                             busy;
    logic                                             ready;
    logic                                             wr_ack;
    logic                                             wr_err;
    logic                                             sel_err;

    modport master (
        output board_enable, board_sel, initial_boards, initial_statuses,
        output wr_en, wr_row, wr_col, wr_value,
        input  game_board, game_status, busy, ready, wr_ack, wr_err, sel_err
    );

    modport slave (
        input  board_enable, board_sel, initial_boards, initial_statuses,
        input  wr_en, wr_row, wr_col, wr_value,
        output game_board, game_status, busy, ready, wr_ack, wr_err, sel_err
    );
endinterface

// File: rtl/board_loader.sv
// Copies a preset puzzle into the live board one cell per cycle, then
// arbitrates player writes against fixed cells and the legal value range.
module board_loader #(
    parameter int N          = 9,
    parameter int VAL_W      = 4,
    parameter int STATUS_W   = 4,
    parameter int NUM_BOARDS = 2,
    parameter int SEL_W      = 1
) (
    input  logic          clock,
    input  logic          reset,
    board_loader_if.slave bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;
    typedef logic [N-1:0][N-1:0][VAL_W-1:0]    board_t;
    typedef logic [N-1:0][N-1:0][STATUS_W-1:0] status_t;

    state_t        state_q, state_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [IW-1:0] sel_q, sel_d;
    board_t        board_q, board_d;
    status_t       status_q, status_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic          serr_q, serr_d;

    logic          start;
    logic          sel_bad;
    logic          in_range;
    logic          wr_ok;
    logic [CW-1:0] wr_r;
    logic [CW-1:0] wr_c;

    assign wr_r     = bus.wr_row[CW-1:0];
    assign wr_c     = bus.wr_col[CW-1:0];
    assign sel_bad  = int'(bus.board_sel) >= NUM_BOARDS;
    // A load request is honoured from IDLE and READY, never mid-load.
    assign start    = bus.board_enable && (state_q != LOAD);
    assign in_range = (int'(bus.wr_row) < N) && (int'(bus.wr_col) < N);
    assign wr_ok    = in_range
                   && (status_q[wr_r][wr_c] == '0)
                   && (int'(bus.wr_value) <= N);

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        sel_d    = sel_q;
        board_d  = board_q;
        status_d = status_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        serr_d   = 1'b0;

        unique case (state_q)
            LOAD: begin
                board_d[row_q][col_q]  = bus.initial_boards[sel_q][row_q][col_q];
                status_d[row_q][col_q] = bus.initial_statuses[sel_q][row_q][col_q];
                if (col_q == CW'(N - 1)) begin
                    col_d = '0;
                    if (row_q == CW'(N - 1)) begin
                        state_d = READY;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            READY: begin
                if (!start && bus.wr_en && wr_ok) begin
                    board_d[wr_r][wr_c] = bus.wr_value;
                end
            end
            default: ;
        endcase

        if (start) begin
            state_d = LOAD;
            row_d   = '0;
            col_d   = '0;
            sel_d   = sel_bad ? '0 : bus.board_sel[IW-1:0];
            serr_d  = sel_bad;
        end

        if (bus.wr_en) begin
            ack_d = (state_q == READY) && !start && wr_ok;
            err_d = !ack_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            sel_q    <= '0;
            board_q  <= '0;
            status_q <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            serr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            sel_q    <= sel_d;
            board_q  <= board_d;
            status_q <= status_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            serr_q   <= serr_d;
        end
    end

    assign bus.game_board  = board_q;
    assign bus.game_status = status_q;
    assign bus.busy        = (state_q == LOAD);
    assign bus.ready       = (state_q == READY);
    assign bus.wr_ack      = ack_q;
    assign bus.wr_err      = err_q;
    assign bus.sel_err     = serr_q;
endmodule
